// File: rtl/scan_imem_loader.sv
// scan_imem_loader: deserializes a scan-pin session (mode, count, address) and streams
// 32-bit words into IMEM (write mode) or shifts IMEM words out on scan_out (read mode).
module scan_imem_loader #(
    parameter int ADDR_W   = 32,
    parameter int ADDR_INC = 4
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic              scan_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, HDR_CNT, HDR_ADDR, WR_DATA, RD_REQ, RD_WAIT, RD_SHIFT, DONE} state_t;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(ADDR_INC);
    state_t state, state_n;
    logic              mode;
    logic [4:0]        bcnt;
    logic [31:0]       cnt, shreg, sh_next;
    logic [ADDR_W-1:0] addr, addr_q;
    logic              last, shifting;
    assign sh_next  = {scan_in, shreg[31:1]};
    assign last     = &bcnt;
    assign shifting = state inside {HDR_CNT, HDR_ADDR, WR_DATA, RD_SHIFT};
    always_ff @(posedge clk or posedge Rst)
        if (Rst) state <= IDLE;
        else     state <= state_n;
    // The read address is presented combinationally in RD_REQ so the strobe and address line up.
    always_comb begin
        state_n   = state;
        mem_re    = state == RD_REQ;
        scan_busy = state != IDLE;
        mem_addr  = state == RD_REQ ? addr : addr_q;
        case (state)
            IDLE:     state_n = scan_en ? HDR_CNT : IDLE;
            HDR_CNT:  state_n = last ? HDR_ADDR : HDR_CNT;
            HDR_ADDR: state_n = !last ? HDR_ADDR : cnt == 0 ? DONE : mode ? WR_DATA : RD_REQ;
            WR_DATA:  state_n = last && cnt == 1 ? DONE : WR_DATA;
            RD_REQ:   state_n = RD_WAIT;
            RD_WAIT:  state_n = RD_SHIFT;
            RD_SHIFT: state_n = !last ? RD_SHIFT : cnt == 1 ? DONE : RD_REQ;
            DONE:     state_n = DONE;
            default:  state_n = IDLE;
        endcase
        if (state != IDLE && !scan_en) state_n = IDLE;
    end
    // A word completed on its 32nd bit is written even if scan_en drops in that same cycle.
    always_ff @(posedge clk or posedge Rst)
        if (Rst) begin
            mode      <= 1'b0;
            bcnt      <= '0;
            cnt       <= '0;
            shreg     <= '0;
            addr      <= '0;
            addr_q    <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            scan_out  <= 1'b0;
        end else begin
            mem_we   <= state == WR_DATA && last;
            scan_out <= scan_en && (state == RD_WAIT ? mem_rdata[0] : state == RD_SHIFT && !last && shreg[1]);
            bcnt     <= shifting ? bcnt + 5'd1 : 5'd0;
            if (state == IDLE) mode <= scan_in;
            if (state inside {HDR_CNT, HDR_ADDR, WR_DATA}) shreg <= sh_next;
            else if (state == RD_WAIT) shreg <= mem_rdata;
            else if (state == RD_SHIFT) shreg <= shreg >> 1;
            if (state == HDR_CNT && last) cnt <= sh_next;
            if (state == HDR_ADDR && last) addr <= sh_next[ADDR_W-1:0];
            if (state == WR_DATA && last) begin
                mem_wdata <= sh_next;
                addr_q    <= addr;
            end
            if ((state == WR_DATA || state == RD_SHIFT) && last) begin
                addr <= addr + INC;
                cnt  <= cnt - 32'd1;
            end
        end
endmodule

// File: tb/tb_scan_imem_loader.sv
// tb_scan_imem_loader: directed scan sessions; expected IMEM strobes and scan_out bits are
// queued at stimulus time and checked by independent monitors.
module tb_scan_imem_loader;
    logic clk = 0, Rst = 1, scan_en = 0, scan_in = 0, sel8 = 0;
    logic en_a, en_b;
    logic so_a, busy_a, we_a, re_a;
    logic [31:0] addr_a, wd_a, rdata = 32'hDEADBEEF;
    logic so_b, busy_b, we_b, re_b;
    logic [7:0] addr_b;
    logic [31:0] wd_b;
    assign en_a = scan_en & ~sel8;
    assign en_b = scan_en & sel8;

    scan_imem_loader dut (
        .clk(clk), .Rst(Rst), .scan_en(en_a), .scan_in(scan_in), .scan_out(so_a), .scan_busy(busy_a),
        .mem_addr(addr_a), .mem_wdata(wd_a), .mem_we(we_a), .mem_re(re_a), .mem_rdata(rdata)
    );
    scan_imem_loader #(.ADDR_W(8)) dut8 (
        .clk(clk), .Rst(Rst), .scan_en(en_b), .scan_in(scan_in), .scan_out(so_b), .scan_busy(busy_b),
        .mem_addr(addr_b), .mem_wdata(wd_b), .mem_we(we_b), .mem_re(re_b), .mem_rdata(32'h0)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int total = 0, bad = 0;

    typedef struct {int c; logic [31:0] a; logic [31:0] d; logic w;} ev_t;
    typedef struct {int c; logic b;} bit_t;
    ev_t  qa[$], q8[$];
    bit_t qbits[$];
    logic [31:0] words [8] = '{32'h00012117, 32'h04010113, 32'h00022517, 32'hFF450513,
                               32'h00A12023, 32'h00012583, 32'h00B50633, 32'h008000EF};

    // One-cycle-latency IMEM model: address sampled mid-cycle, data valid the following cycle.
    logic re_s = 0;
    logic [31:0] addr_s = 0;
    always @(negedge clk) begin
        re_s   <= re_a;
        addr_s <= addr_a;
    end
    always @(posedge clk)
        rdata <= !re_s ? 32'hDEADBEEF : addr_s == 32'h4 ? 32'h04010113 : addr_s == 32'h8 ? 32'h00022517 : 32'hBADBAD00;

    always @(negedge clk) begin
        ev_t e;
        bit_t x;
        if (we_a || re_a) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL ev_a unexpected we=%0b re=%0b addr=%h cyc=%0d", we_a, re_a, addr_a, cyc);
            end else begin
                e = qa.pop_front();
                if (we_a !== e.w || re_a !== !e.w || cyc != e.c || addr_a !== e.a || (e.w && wd_a !== e.d)) begin
                    bad++;
                    $display("FAIL ev_a got we=%0b re=%0b addr=%h data=%h cyc=%0d want w=%0b addr=%h data=%h cyc=%0d",
                             we_a, re_a, addr_a, wd_a, cyc, e.w, e.a, e.d, e.c);
                end
            end
        end
        if (qbits.size() != 0 && qbits[0].c == cyc) begin
            x = qbits.pop_front();
            total++;
            if (so_a !== x.b) begin
                bad++;
                $display("FAIL scan_out cyc=%0d got %0b want %0b", cyc, so_a, x.b);
            end
        end else if (so_a !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL scan_out_idle cyc=%0d got %0b want 0", cyc, so_a);
        end
        if (we_b || re_b) begin
            total++;
            if (q8.size() == 0 || re_b) begin
                bad++;
                $display("FAIL ev_8 unexpected we=%0b re=%0b addr=%h cyc=%0d", we_b, re_b, addr_b, cyc);
            end else begin
                e = q8.pop_front();
                if (cyc != e.c || addr_b !== e.a[7:0] || wd_b !== e.d) begin
                    bad++;
                    $display("FAIL ev_8 got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             addr_b, wd_b, cyc, e.a[7:0], e.d, e.c);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask
    task automatic drive(input logic en, input logic b);
        @(posedge clk);
        #1;
        scan_en = en;
        scan_in = b;
    endtask
    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) drive(1, w[i]);
    endtask
    task automatic header(input logic m, input logic [31:0] c, input logic [31:0] a, output int t0);
        drive(1, m);
        t0 = cyc;
        for (int i = 0; i < 32; i++) drive(1, c[i]);
        for (int i = 0; i < 32; i++) drive(1, a[i]);
    endtask
    task automatic push_word_bits(input int c0, input logic [31:0] w);
        for (int i = 0; i < 32; i++) qbits.push_back('{c0 + i, w[i]});
    endtask

    initial begin
        int t0;
        logic [31:0] c3;
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_re", re_a, 0);
        chk("rst_scan_out", so_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wd_a, 0);
        chk("rst_busy8", busy_b, 0);
        repeat (2) @(posedge clk);
        #1 Rst = 0;

        header(1, 8, 0, t0);
        for (int k = 0; k < 8; k++) qa.push_back('{t0 + 97 + 32 * k, 32'(4 * k), words[k], 1'b1});
        for (int k = 0; k < 8; k++) send_word(words[k]);
        repeat (3) drive(1, 0);
        @(negedge clk) chk("wr_done_busy", busy_a, 1);
        drive(0, 0);
        drive(0, 0);
        @(negedge clk) chk("wr_idle_busy", busy_a, 0);

        header(0, 2, 32'h4, t0);
        qa.push_back('{t0 + 65, 32'h4, 32'h0, 1'b0});
        qa.push_back('{t0 + 99, 32'h8, 32'h0, 1'b0});
        push_word_bits(t0 + 67, 32'h04010113);
        push_word_bits(t0 + 101, 32'h00022517);
        repeat (68) drive(1, 1'($urandom_range(0, 1)));
        repeat (2) drive(1, 1);
        @(negedge clk) chk("rd_done_busy", busy_a, 1);
        drive(0, 0);
        drive(0, 0);
        @(negedge clk) chk("rd_idle_busy", busy_a, 0);

        header(1, 0, 32'h10, t0);
        repeat (4) drive(1, 1);
        @(negedge clk) chk("zero_done_busy", busy_a, 1);
        drive(0, 0);
        drive(0, 0);
        @(negedge clk) chk("zero_idle_busy", busy_a, 0);

        header(1, 32'hFFFFFFFF, 32'h40, t0);
        qa.push_back('{t0 + 97, 32'h40, 32'h13579BDF, 1'b1});
        send_word(32'h13579BDF);
        repeat (16) drive(1, 1);
        drive(0, 1);
        @(negedge clk) chk("abort_fall_busy", busy_a, 1);
        drive(0, 0);
        @(negedge clk) begin
            chk("abort_busy", busy_a, 0);
            chk("abort_we", we_a, 0);
        end

        c3 = 32'd3;
        drive(1, 1);
        for (int i = 0; i < 32; i++) drive(1, c3[i]);
        repeat (10) drive(1, 1);
        #3;
        Rst = 1;
        scan_en = 0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_we", we_a, 0);
        chk("arst_re", re_a, 0);
        chk("arst_scan_out", so_a, 0);
        chk("arst_addr", addr_a, 0);
        chk("arst_wdata", wd_a, 0);
        @(posedge clk);
        #1 Rst = 0;
        header(1, 1, 32'h80, t0);
        qa.push_back('{t0 + 97, 32'h80, 32'hCAFE0F0F, 1'b1});
        send_word(32'hCAFE0F0F);
        repeat (2) drive(1, 0);
        @(negedge clk) chk("post_rst_busy", busy_a, 1);
        drive(0, 0);
        drive(0, 0);
        @(negedge clk) chk("post_rst_idle", busy_a, 0);

        sel8 = 1;
        header(1, 2, 32'hFC, t0);
        q8.push_back('{t0 + 97, 32'hFC, 32'hA5A5_0001, 1'b1});
        q8.push_back('{t0 + 129, 32'h00, 32'h5A5A_0002, 1'b1});
        send_word(32'hA5A5_0001);
        send_word(32'h5A5A_0002);
        repeat (2) drive(1, 0);
        @(negedge clk) chk("wrap_done_busy", busy_b, 1);
        drive(0, 0);
        drive(0, 0);
        @(negedge clk) chk("wrap_idle_busy", busy_b, 0);
        sel8 = 0;

        repeat (3) drive(0, 0);
        @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("qbits_drained", qbits.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_imem_loader.md
# scan_imem_loader

Scan-chain target that sits between the chip-level scan pins and the instruction memory port of `rv_uart_top`. It deserializes the host's serial scan protocol: a mode bit, a 32-bit word count and a 32-bit start address, all LSB-first. In write mode it then collects 32-bit words and writes them into IMEM. In read mode it fetches IMEM words and shifts them out on `scan_out`. `scan_busy` holds the core off while a session is active.

## Interface
- `ADDR_W`, 32: width of `mem_addr`; addresses wrap modulo 2^ADDR_W.
- `ADDR_INC`, 4: byte increment of `mem_addr` per word.
- `clk` in 1: single clock; scan bits are sampled on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `scan_en` in 1: session enable; its low level aborts any session.
- `scan_in` in 1: serial data in, LSB-first.
- `scan_out` out 1: serial read data, registered.
- `scan_busy` out 1: high in every state except IDLE.
- `mem_addr` out ADDR_W: IMEM byte address.
- `mem_wdata` out 32: IMEM write data.
- `mem_we` out 1: one-cycle IMEM write strobe.
- `mem_re` out 1: one-cycle IMEM read strobe; read latency is 1 cycle.
- `mem_rdata` in 32: IMEM read data, valid the cycle after `mem_re`.

## Operation
- States: IDLE, HDR_CNT, HDR_ADDR, WR_DATA, RD_REQ, RD_WAIT, RD_SHIFT, DONE.
- IDLE to HDR_CNT: `scan_en`=1. `scan_in` in that cycle is latched as the mode bit (1=write, 0=read).
- HDR_CNT: shifts 32 bits into `cnt`. HDR_ADDR: shifts 32 bits into `addr`; only the low ADDR_W bits are kept.
- After the last address bit:
  - `cnt`==0 goes to DONE.
  - Otherwise write mode goes to WR_DATA and read mode goes to RD_REQ.
- WR_DATA: shifts 32 bits. On the 32nd bit the word is copied to a `mem_wdata` holding register and `mem_we` is pulsed the next cycle with `mem_addr`=`addr`. Then `addr`+=ADDR_INC and `cnt`-=1.
  - `cnt` reaching 0 goes to DONE.
  - Otherwise the state stays in WR_DATA, with no gap between words. The strobe for word k overlaps bit 0 of word k+1.
- RD_REQ (1 cycle): `mem_re`=1, `mem_addr`=`addr`.
- RD_WAIT (1 cycle): `mem_rdata` is loaded into the shift register.
- RD_SHIFT (32 cycles): `scan_out`=shreg[0], and the register shifts right each cycle. After bit 31: `addr`+=ADDR_INC, `cnt`-=1, then go to DONE if `cnt`==0, else RD_REQ.
- `scan_out`=0 in every state other than RD_SHIFT. `scan_in` is ignored during read data.
- DONE: ignores `scan_in` and keeps `scan_busy`=1 until `scan_en`=0.
- `scan_en`=0 in any state returns to IDLE the next cycle:
  - A partial word is discarded and no `mem_we` is issued for it.
  - A `mem_we` already registered for a completed word still occurs.
- `cnt` is 32-bit unsigned. 0xFFFFFFFF acts as effectively unbounded; the session is ended by dropping `scan_en`.
- Simultaneous events: if `scan_en` falls on the cycle of the 32nd bit, the word still completes and is written. `scan_en` is sampled for the abort only from the following cycle.

## Timing
- Cycle 0 is the first cycle with `scan_en`=1 (mode bit). Count bits occupy cycles 1–32; address bits occupy cycles 33–64.
- Write, word k:
  - Bits at cycles 65+32k .. 96+32k.
  - `mem_we`=1 in cycle 97+32k, with `mem_addr`=start+ADDR_INC·k.
- Read, word k:
  - `mem_re` at cycle 65+34k.
  - Bit i on `scan_out` during cycle 67+34k+i.
  - Word pitch is 34 cycles.
- Abort latency: outputs are in their idle values one cycle after `scan_en` falls.
- Reset values: state=IDLE; `scan_out`=0; `scan_busy`=0; `mem_we`=0; `mem_re`=0; `mem_addr`=0; `mem_wdata`=0; `cnt`=0; shift register=0. Asserting `Rst` mid-session clears everything immediately with no write.

## Test plan
- Write 8 words: mode 1, cnt 8, addr 0, words 0x00012117 .. 0x008000EF. Expect 8 `mem_we` pulses at cycles 97+32k, addresses 0x00..0x1C, data matching, then DONE with `scan_busy`=1 until `scan_en` falls.
- Read back: mode 0, cnt 2, addr 0x4, memory model returns 0x04010113 and 0x00022517. Expect `mem_re` at cycles 65 and 99, and `scan_out` producing those words LSB-first from cycles 67 and 101.
- Zero count: mode 1, cnt 0. Expect DONE at cycle 65 and no `mem_we` or `mem_re`.
- Abort: cnt 0xFFFFFFFF, one full word, then drop `scan_en` after 16 bits of word 2. Expect exactly one `mem_we`, IDLE the next cycle, and `scan_busy`=0.
- Async reset: assert `Rst` mid-HDR_ADDR, between clock edges. Expect all outputs 0 immediately, and a fresh session afterwards that works normally.
- Wrap: ADDR_W=8, start 0xFC, cnt 2. Expect writes at 0xFC then 0x00.
